bus_grant_arbiter: RTL and testbench
====================================

Name: bus_grant_arbiter

Overview:
- Round-robin arbiter for the shared 32-source CPU bus.
- Decides which of 32 requesters (registers, PC, MDR, ALU result, …) drives the bus, and holds that grant for a bounded tenure.
- Emits a registered one-hot select for the bus source-select encoder, plus the matching 5-bit index.
- Sits between the control unit's per-source drive requests and the bus mux select logic.

Parameters:
- N, 32: number of requesters. Fixed at 32 to match the 5-bit bus select.
- HOLD_MAX, 16: maximum owned cycles before forced preemption, if another requester is waiting. Legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- req  in  32  per-source bus request, level, bit i = source i.
- done  in  1  owner release strobe, sampled only in OWN.
- grant  out  32  registered one-hot bus-drive select; all-zero when bus idle.
- grant_idx  out  5  registered binary index of the grant bit; 0 when idle.
- busy  out  1  high while in OWN.
- preempt  out  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset values (async on clr_n low): grant=0, grant_idx=0, busy=0, preempt=0, state=IDLE, hold_cnt=0, last_idx=31. Consequently the first search starts at source 0.
- State IDLE: grant=0.
  - If req!=0, pick the first set bit scanning last_idx+1, last_idx+2, … wrapping modulo 32.
  - Next edge: grant=onehot(pick), grant_idx=pick, last_idx=pick, hold_cnt=1, state=OWN.
  - Latency: req seen at edge t gives grant valid after edge t+1 (one cycle).
- State OWN: grant and grant_idx stable, busy=1, hold_cnt increments each cycle and saturates at HOLD_MAX.
  - Release if done=1, or req[grant_idx]=0 (owner dropped request).
  - Release: next edge grant=0, busy=0, state=GAP.
  - Preempt if hold_cnt==HOLD_MAX and any other req bit is set, with no release condition that cycle. Next edge: state=GAP, grant=0, preempt=1 for that one cycle.
  - If hold_cnt==HOLD_MAX and no other requester is pending: stay in OWN, no preempt.
- State GAP: exactly one bus-turnaround cycle with grant=0, so no two sources ever drive in adjacent cycles.
  - Arbitration is evaluated in GAP exactly as in IDLE.
  - If req!=0, the next edge goes straight to OWN with the new grant; otherwise go to IDLE.
  - Back-to-back owners are therefore separated by exactly one idle cycle.
- Fairness:
  - A preempted owner is not re-granted ahead of others, because last_idx=its index.
  - If it is the only requester left in GAP, it is re-granted.
  - Any requester holding req continuously is granted within 31*(HOLD_MAX+1) cycles.
- Simultaneous events in OWN:
  - done and timeout in the same cycle: treat as a normal release, preempt=0.
  - done while the owner's req stays high: still a release. The owner re-competes from GAP.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant_idx always equals the encode of grant.
  - req changes in non-owner bits never disturb a held grant.
- Reset mid-OWN: grant drops to 0 asynchronously; no preempt pulse.
- All outputs come from flops; no combinational path from req or done to grant.

Decomposition:
- Shared package holds:
  - state enum {IDLE, OWN, GAP} (2 bits);
  - constants BUS_SRC_N=32, BUS_SEL_W=5;
  - HOLD_MAX default.
- One sub-module: rr_pick_32.
  - Purely combinational rotating-priority finder.
  - Inputs: req[31:0], start[4:0].
  - Outputs: pick[4:0], any.
  - Implemented by rotating req right by start, priority-encoding from the LSB, then adding start back mod 32.
- The top level holds the FSM, hold counter, and output registers.

Test Plan:
- Reset then req=0x0000_0001 at cycle 0 -> grant=0x0000_0001, grant_idx=0, busy=1 after the first edge. done pulse -> one GAP cycle with grant=0, then IDLE.
- req=0x8000_0003 held, each owner asserting done after 2 owned cycles -> grant order idx 0,1,31,0 with one grant=0 cycle between each.
- req=0x0000_0011, owner 0 never asserts done, HOLD_MAX=16 -> after 16 owned cycles preempt=1 for one cycle, then grant=0x0000_0010 (idx 4).
- req=0x0000_0004 alone, never done -> grant held indefinitely past 16 cycles, preempt stays 0.
- In OWN idx 4, done=1 on the cycle hold_cnt hits 16 with req[9]=1 -> preempt=0, GAP, then grant idx 9.
- clr_n low in the middle of an OWN tenure -> grant=0, busy=0 immediately. After release with req=0x0000_0100, grant idx 8, since search restarts from 0.

Source files
------------

// File: rtl/bus_grant_arbiter_pkg.sv
// Shared types and constants for the CPU bus grant arbiter.
// The bus select is 5 bits wide, so the requester count is tied to 32.
package bus_grant_arbiter_pkg;

    localparam int BUS_SRC_N    = 32;
    localparam int BUS_SEL_W    = 5;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    function automatic logic [BUS_SRC_N-1:0] sel_onehot(input logic [BUS_SEL_W-1:0] idx);
        return {{(BUS_SRC_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/bus_grant_arbiter_pick.sv
// Combinational rotating-priority finder: first set request at or after start_i,
// wrapping modulo 32.
module rr_pick_32
    import bus_grant_arbiter_pkg::*;
(
    input  logic [BUS_SRC_N-1:0] req_i,
    input  logic [BUS_SEL_W-1:0] start_i,
    output logic [BUS_SEL_W-1:0] pick_o,
    output logic                 any_o
);

    logic [BUS_SRC_N-1:0] rot;
    logic [BUS_SEL_W-1:0] enc;

    always_comb begin
        // A shift by 32 when start_i is 0 yields zero, so the OR stays correct.
        rot = (req_i >> start_i) | (req_i << (6'd32 - {1'b0, start_i}));
        enc = '0;
        for (int i = BUS_SRC_N - 1; i >= 0; i--) begin
            if (rot[i]) enc = BUS_SEL_W'(i);
        end
        pick_o = enc + start_i;
        any_o  = |req_i;
    end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus grant arbiter with bounded tenure and a one-cycle turnaround gap.
//   state | meaning
//   IDLE  | bus undriven, arbitrating every cycle
//   OWN   | one source holds the bus; tenure counted in hold_cnt_q
//   GAP   | single turnaround cycle after a release or preemption, arbitrating
module bus_grant_arbiter
    import bus_grant_arbiter_pkg::*;
#(
    parameter int N        = BUS_SRC_N,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic [BUS_SEL_W-1:0] grant_idx,
    output logic                 busy,
    output logic                 preempt
);

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

    arb_state_e           state_q;
    logic [N-1:0]         grant_q;
    logic [BUS_SEL_W-1:0] grant_idx_q;
    logic [BUS_SEL_W-1:0] last_idx_q;
    logic [7:0]           hold_cnt_q;
    logic [7:0]           hold_cnt_d;
    logic                 busy_q;
    logic                 preempt_q;

    logic [BUS_SEL_W-1:0] start;
    logic [BUS_SEL_W-1:0] pick;
    logic                 any_req;
    logic                 owner_rel;
    logic                 others_wait;
    logic                 at_max;

    rr_pick_32 u_pick (
        .req_i   (req),
        .start_i (start),
        .pick_o  (pick),
        .any_o   (any_req)
    );

    always_comb begin
        start       = last_idx_q + BUS_SEL_W'(1);
        owner_rel   = done | ~req[grant_idx_q];
        others_wait = |(req & ~grant_q);
        at_max      = (hold_cnt_q == HOLD_MAX_C);
        hold_cnt_d  = at_max ? hold_cnt_q : hold_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= BUS_SEL_W'(BUS_SRC_N - 1);
            hold_cnt_q  <= '0;
            busy_q      <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (any_req) begin
                        state_q     <= OWN;
                        grant_q     <= sel_onehot(pick);
                        grant_idx_q <= pick;
                        last_idx_q  <= pick;
                        hold_cnt_q  <= 8'd1;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OWN: begin
                    // A voluntary release always wins over a coincident timeout.
                    if (owner_rel || (at_max && others_wait)) begin
                        state_q     <= GAP;
                        grant_q     <= '0;
                        grant_idx_q <= '0;
                        hold_cnt_q  <= '0;
                        busy_q      <= 1'b0;
                        preempt_q   <= ~owner_rel;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against an ownership-level reference model.
module tb_bus_grant_arbiter;

    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] req = '0;
    logic        done = 1'b0;
    logic [31:0] grant;
    logic [4:0]  grant_idx;
    logic        busy;
    logic        preempt;

    int n_checks = 0;
    int n_pass   = 0;

    bus_grant_arbiter #(.N(32), .HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, for how long, and who was served last.
    int m_owner;
    int m_held;
    int m_last;
    bit m_pre;

    function automatic int next_after(input int last, input logic [31:0] r);
        for (int k = 1; k <= 32; k++) begin
            if (r[(last + k) % 32]) return (last + k) % 32;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_owner <= -1;
            m_held  <= 0;
            m_last  <= 31;
            m_pre   <= 1'b0;
        end else begin
            m_pre <= 1'b0;
            if (m_owner >= 0) begin
                if (done || !req[m_owner]) begin
                    m_owner <= -1;
                end else if (m_held >= HOLD && (req & ~(32'd1 << m_owner)) != 0) begin
                    m_owner <= -1;
                    m_pre   <= 1'b1;
                end else if (m_held < HOLD) begin
                    m_held <= m_held + 1;
                end
            end else if (req != 0) begin
                m_owner <= next_after(m_last, req);
                m_last  <= next_after(m_last, req);
                m_held  <= 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (grant !== 32'h0) $display("FAIL reset_grant got %h want 0", grant);
        else n_pass++;
        n_checks++;
        if (grant_idx !== 5'd0) $display("FAIL reset_idx got %0d want 0", grant_idx);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || preempt !== 1'b0)
            $display("FAIL reset_flags got busy=%b preempt=%b want 0 0", busy, preempt);
        else n_pass++;
    endtask

    task automatic test_single_done();
        do_reset();
        req = 32'h0000_0001;
        tick();
        n_checks++;
        if (grant !== 32'h1 || grant_idx !== 5'd0 || busy !== 1'b1)
            $display("FAIL single_grant got %h/%0d/%b want 00000001/0/1", grant, grant_idx, busy);
        else n_pass++;
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
        n_checks++;
        if (grant !== 32'h0 || busy !== 1'b0 || preempt !== 1'b0)
            $display("FAIL single_gap got %h/%b/%b want 0/0/0", grant, busy, preempt);
        else n_pass++;
        tick();
        n_checks++;
        if (grant !== 32'h0 || busy !== 1'b0)
            $display("FAIL single_idle got %h/%b want 0/0", grant, busy);
        else n_pass++;
    endtask

    task automatic test_rr_order();
        int order [4] = '{0, 1, 31, 0};
        do_reset();
        req = 32'h8000_0003;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (grant !== (32'd1 << order[i]) || grant_idx !== 5'(order[i]))
                $display("FAIL rr_grant%0d got %h/%0d want idx %0d", i, grant, grant_idx, order[i]);
            else n_pass++;
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            n_checks++;
            if (grant !== 32'h0 || busy !== 1'b0)
                $display("FAIL rr_gap%0d got %h/%b want 0/0", i, grant, busy);
            else n_pass++;
            tick();
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_preempt();
        int bad = 0;
        do_reset();
        req = 32'h0000_0011;
        tick();
        for (int i = 1; i < HOLD; i++) begin
            if (grant !== 32'h1 || preempt !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0 || grant !== 32'h1)
            $display("FAIL preempt_hold got %0d bad cycles, grant %h want 0 bad, 00000001", bad, grant);
        else n_pass++;
        tick();
        n_checks++;
        if (preempt !== 1'b1 || grant !== 32'h0)
            $display("FAIL preempt_pulse got preempt=%b grant=%h want 1/0", preempt, grant);
        else n_pass++;
        tick();
        n_checks++;
        if (preempt !== 1'b0 || grant !== 32'h10 || grant_idx !== 5'd4)
            $display("FAIL preempt_next got %b/%h/%0d want 0/00000010/4", preempt, grant, grant_idx);
        else n_pass++;
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_no_preempt_alone();
        int bad = 0;
        do_reset();
        req = 32'h0000_0004;
        tick();
        for (int i = 0; i < 3 * HOLD; i++) begin
            if (grant !== 32'h4 || grant_idx !== 5'd2 || preempt !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL alone_hold got %0d bad cycles want 0", bad);
        else n_pass++;
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        req = 32'h0000_0210;
        tick();
        n_checks++;
        if (grant_idx !== 5'd4) $display("FAIL dto_first got idx %0d want 4", grant_idx);
        else n_pass++;
        for (int i = 1; i < HOLD; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (preempt !== 1'b0 || grant !== 32'h0)
            $display("FAIL dto_gap got preempt=%b grant=%h want 0/0", preempt, grant);
        else n_pass++;
        tick();
        n_checks++;
        if (grant !== 32'h200 || grant_idx !== 5'd9)
            $display("FAIL dto_next got %h/%0d want 00000200/9", grant, grant_idx);
        else n_pass++;
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_own();
        do_reset();
        req = 32'h0000_0040;
        tick();
        tick();
        tick();
        n_checks++;
        if (grant !== 32'h40 || busy !== 1'b1)
            $display("FAIL midrst_own got %h/%b want 00000040/1", grant, busy);
        else n_pass++;
        #2;
        clr_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 32'h0 || busy !== 1'b0 || preempt !== 1'b0)
            $display("FAIL midrst_async got %h/%b/%b want 0/0/0", grant, busy, preempt);
        else n_pass++;
        req = 32'h0000_0100;
        tick();
        clr_n = 1'b1;
        tick();
        n_checks++;
        if (grant !== 32'h100 || grant_idx !== 5'd8)
            $display("FAIL midrst_regrant got %h/%0d want 00000100/8", grant, grant_idx);
        else n_pass++;
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp_grant;
        logic [4:0]  exp_idx;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = '0;
                    1: req = 32'd1 << $urandom_range(0, 31);
                    2: req = $urandom & $urandom & $urandom;
                    default: req = $urandom;
                endcase
            end
            done = ($urandom_range(0, 24) == 0);
            tick();
            exp_grant = (m_owner < 0) ? 32'h0 : (32'd1 << m_owner);
            exp_idx   = (m_owner < 0) ? 5'd0 : 5'(m_owner);
            n_checks++;
            if (grant !== exp_grant || grant_idx !== exp_idx || busy !== (m_owner >= 0) || preempt !== m_pre)
                $display("FAIL random_c%0d got %h/%0d/%b/%b want %h/%0d/%b/%b", c,
                         grant, grant_idx, busy, preempt, exp_grant, exp_idx, (m_owner >= 0), m_pre);
            else n_pass++;
        end
        done = 1'b0;
        req  = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_done();
        test_rr_order();
        test_preempt();
        test_no_preempt_alone();
        test_done_at_timeout();
        test_reset_mid_own();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
